wb_data_stage: RTL
==================

// Module: wb_data_stage
// PURPOSE
//  Write-back stage for the redirect pipeline: a registered MEM/WB boundary that forms
//  register-file write data from ALU result, load data (byte/half/word, signed/unsigned),
//  link address (jal) or LUI immediate, then presents it to the register file and to the
//  forwarding network. Adds stall/flush control, alignment checking and a retired-write counter.
// PARAMETERS
//  XLEN       32  datapath width; must be 32 (lui/halfword rules defined for 32 only)
//  LINK_OFF   4   offset added to pc for link-address write-back
//  LINK_REG   31  destination register forced for jal
//  CNT_W      32  width of retired-write counter
// PORTS
//  clk        in   1      pipeline clock
//  rst        in   1      asynchronous reset, active-high
//  in_valid   in   1      MEM stage holds a valid instruction
//  stall      in   1      hold WB register contents
//  flush      in   1      kill instruction entering WB
//  op         in   6      opcode of MEM-stage instruction
//  sel        in   2      byte offset of load address (addr[1:0])
//  we         in   1      instruction writes a register
//  waddr      in   5      destination register
//  dmdout     in   XLEN   data-memory read word
//  aluout     in   XLEN   ALU result
//  pc         in   XLEN   instruction address
//  imm        in   16     instruction immediate
//  wb_valid   out  1      WB register holds a valid instruction
//  rf_we      out  1      register-file write enable
//  rf_waddr   out  5      register-file write address
//  rf_wdata   out  XLEN   register-file write data (also forwarding source)
//  align_err  out  1      one-cycle pulse: misaligned halfword/word load retired
//  wb_count   out  CNT_W  number of register writes performed (saturating)
// BEHAVIOUR
//  - Reset (async, rst=1): wb_valid=0, rf_we=0, rf_waddr=0, rf_wdata=0, align_err=0, wb_count=0.
//  - Latency: 1 cycle. Data formed combinationally from MEM inputs, captured on posedge clk.
//  - Capture priority each posedge: flush > stall > load.
//    flush=1: wb_valid=0, rf_we=0, align_err=0; rf_waddr/rf_wdata don't-care (held).
//    stall=1 (no flush): all WB registers hold; align_err forced 0 (pulse not repeated);
//      wb_count not incremented while held.
//    else: wb_valid<=in_valid; other fields loaded from formed values.
//  - Data formation (little-endian; byte b = dmdout[8*sel+7:8*sel], half h = dmdout[16*sel[1]+15:16*sel[1]]):
//    op 6'h20 lb  : sign-extend b        op 6'h24 lbu : zero-extend b
//    op 6'h21 lh  : sign-extend h        op 6'h25 lhu : zero-extend h
//    op 6'h23 lw  : dmdout               op 6'h03 jal : pc+LINK_OFF (mod 2^XLEN), waddr forced LINK_REG
//    op 6'h0F lui : {imm,16'h0000}       any other op : aluout
//  - Alignment: lh/lhu with sel[0]=1, or lw with sel!=0, is misaligned: rf_we=0 for that
//    instruction and align_err=1 for exactly the cycle after capture (only if in_valid).
//  - rf_we = wb_valid & (we | jal) & (dest!=0) & ~misaligned. Writes to $0 never asserted.
//  - wb_count increments by 1 on each capture that yields rf_we=1 (visible same cycle
//    rf_we rises); saturates at all-ones, never wraps.
//  - in_valid=0 captures: wb_valid=0, rf_we=0, data fields still loaded (don't-care).
//  - Reset mid-operation discards the WB instruction; no write occurs on the reset edge.
// TESTING
//  1 lbu/lb: dmdout=32'h80FF7F01, sel=2'd3, op=6'h24 -> rf_wdata=32'h00000080; op=6'h20 -> 32'hFFFFFF80.
//  2 lh sel=2 dmdout=32'h8001_1234 -> 32'hFFFF8001; lhu sel=1 -> rf_we=0, align_err pulses 1 cycle.
//  3 jal pc=32'hFFFFFFFC, waddr=5 -> rf_wdata=32'h00000000, rf_waddr=31, rf_we=1.
//  4 lui imm=16'hABCD -> 32'hABCD0000; ALU op waddr=0 aluout=7 -> rf_we=0, wb_count unchanged.
//  5 stall 3 cycles after lw -> outputs frozen, wb_count +1 only; flush+stall together -> wb_valid=0.
//  6 rst asserted mid-stream (async, between edges) -> all outputs 0 immediately; CNT_W=2: 5 writes -> wb_count=3.

Source files
------------

// File: rtl/wb_data_stage_if.sv
// MEM/WB boundary bundle: MEM-stage instruction fields in, write-back
// register-file / forwarding outputs back.
interface wb_data_stage_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
);
    // MEM-stage side
    logic             in_valid;
    logic             stall;
    logic             flush;
    logic [5:0]       op;
    logic [1:0]       sel;
    logic             we;
    logic [4:0]       waddr;
    logic [XLEN-1:0]  dmdout;
    logic [XLEN-1:0]  aluout;
    logic [XLEN-1:0]  pc;
    logic [15:0]      imm;

    // WB-stage side
    logic             wb_valid;
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic [XLEN-1:0]  rf_wdata;
    logic             align_err;
    logic [CNT_W-1:0] wb_count;

    // Pipeline control / MEM stage drives the instruction, observes WB
    modport master (
        output in_valid, stall, flush, op, sel, we, waddr,
               dmdout, aluout, pc, imm,
        input  wb_valid, rf_we, rf_waddr, rf_wdata, align_err, wb_count
    );

    // The write-back stage itself
    modport slave (
        input  in_valid, stall, flush, op, sel, we, waddr,
               dmdout, aluout, pc, imm,
        output wb_valid, rf_we, rf_waddr, rf_wdata, align_err, wb_count
    );
endinterface

// File: rtl/wb_data_stage.sv
// Write-back stage: registered MEM/WB boundary forming register-file write
// data from ALU result, sized/signed load data, link address or LUI value,
// with stall/flush control, load alignment checking and a saturating
// retired-write counter.
module wb_data_stage #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned LINK_OFF = 4,
    parameter int unsigned LINK_REG = 31,
    parameter int unsigned CNT_W    = 32
) (
    input  logic            clk,
    input  logic            rst,
    wb_data_stage_if.slave  bus
);

    typedef enum logic [5:0] {
        OP_JAL = 6'h03,
        OP_LUI = 6'h0F,
        OP_LB  = 6'h20,
        OP_LH  = 6'h21,
        OP_LW  = 6'h23,
        OP_LBU = 6'h24,
        OP_LHU = 6'h25
    } op_e;

    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic            is_jal;
    logic            misaligned;
    logic [4:0]      dest;
    logic [XLEN-1:0] wdata_n;
    logic            rf_we_n;
    logic            align_n;

    // Extract the addressed byte and halfword from the little-endian word
    always_comb begin
        ld_byte = bus.dmdout[{bus.sel, 3'b000} +: 8];
        ld_half = bus.dmdout[{bus.sel[1], 4'b0000} +: 16];
    end

    // Form write data, destination and write enable for the MEM-stage instruction
    always_comb begin
        is_jal     = 1'b0;
        misaligned = 1'b0;
        wdata_n    = bus.aluout;
        case (bus.op)
            OP_LB:  wdata_n = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            OP_LBU: wdata_n = {{(XLEN-8){1'b0}}, ld_byte};
            OP_LH: begin
                wdata_n    = {{(XLEN-16){ld_half[15]}}, ld_half};
                misaligned = bus.sel[0];
            end
            OP_LHU: begin
                wdata_n    = {{(XLEN-16){1'b0}}, ld_half};
                misaligned = bus.sel[0];
            end
            OP_LW: begin
                wdata_n    = bus.dmdout;
                misaligned = (bus.sel != 2'b00);
            end
            OP_JAL: begin
                wdata_n = bus.pc + XLEN'(LINK_OFF);
                is_jal  = 1'b1;
            end
            OP_LUI: wdata_n = {bus.imm, {(XLEN-16){1'b0}}};
            default: wdata_n = bus.aluout;
        endcase
        dest    = is_jal ? 5'(LINK_REG) : bus.waddr;
        rf_we_n = bus.in_valid & (bus.we | is_jal) & (dest != 5'd0) & ~misaligned;
        align_n = bus.in_valid & misaligned;
    end

    // WB pipeline register: flush kills, stall holds, otherwise capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.wb_valid  <= 1'b0;
            bus.rf_we     <= 1'b0;
            bus.rf_waddr  <= '0;
            bus.rf_wdata  <= '0;
            bus.align_err <= 1'b0;
        end else if (bus.flush) begin
            bus.wb_valid  <= 1'b0;
            bus.rf_we     <= 1'b0;
            bus.align_err <= 1'b0;
        end else if (bus.stall) begin
            // Held instruction must not re-report its alignment fault
            bus.align_err <= 1'b0;
        end else begin
            bus.wb_valid  <= bus.in_valid;
            bus.rf_we     <= rf_we_n;
            bus.rf_waddr  <= dest;
            bus.rf_wdata  <= wdata_n;
            bus.align_err <= align_n;
        end
    end

    // Count captures that produce a register write, saturating at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.wb_count <= '0;
        end else if (!bus.flush && !bus.stall && rf_we_n && (bus.wb_count != '1)) begin
            bus.wb_count <= bus.wb_count + CNT_W'(1);
        end
    end

endmodule
